// File: rtl/tt_sweep_checker.sv
// Exhaustive 4-input truth-table checker: sweeps a..d through 0..15, samples x after
// SETTLE cycles per vector and compares the captured table against EXPECTED.
module tt_sweep_checker #(
  parameter logic [15:0] EXPECTED = 16'h0000,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        x_i,
  output logic        a_o,
  output logic        b_o,
  output logic        c_o,
  output logic        d_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] captured_o,
  output logic [4:0]  mismatches_o,
  output logic [3:0]  fail_idx_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] captured_q, captured_d;
  logic [4:0]  mism_q, mism_d;
  logic [3:0]  failIdx_q, failIdx_d;
  logic        firstFail_q, firstFail_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      vec_q       <= 4'd0;
      cnt_q       <= 8'd0;
      captured_q  <= 16'h0000;
      mism_q      <= 5'd0;
      failIdx_q   <= 4'd0;
      firstFail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      mism_q      <= mism_d;
      failIdx_q   <= failIdx_d;
      firstFail_q <= firstFail_d;
    end
  end

  // Start is honoured from IDLE and DONE alike; in DRIVE it is ignored.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    captured_d  = captured_q;
    mism_d      = mism_q;
    failIdx_d   = failIdx_q;
    firstFail_d = firstFail_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = DRIVE;
          vec_d       = 4'd0;
          cnt_d       = SETTLE_M1;
          captured_d  = 16'h0000;
          mism_d      = 5'd0;
          failIdx_d   = 4'd0;
          firstFail_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == 8'd0) begin
          captured_d[vec_q] = x_i;
          if (x_i != EXPECTED[vec_q]) begin
            mism_d = mism_q + 5'd1;
            if (!firstFail_q) begin
              failIdx_d   = vec_q;
              firstFail_d = 1'b1;
            end
          end
          // The sample edge also presents the next vector; vec stays at 15 once done.
          if (vec_q == 4'hF) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 4'd1;
            cnt_d = SETTLE_M1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // vec is 0 in IDLE and 15 in DONE, so the stimulus can come straight from it.
  assign {a_o, b_o, c_o, d_o} = vec_q;
  assign busy_o       = (state_q == DRIVE);
  assign done_o       = (state_q == DONE);
  assign pass_o       = (state_q == DONE) && (mism_q == 5'd0);
  assign captured_o   = captured_q;
  assign mismatches_o = mism_q;
  assign fail_idx_o   = failIdx_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: three instances cover the AND/zero, parity and
// SETTLE=3 OR cases, all sharing clock, reset and start.
module tb_tt_sweep_checker;

  logic clk;
  logic rst;
  logic start;
  logic mode;

  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] cap1;
  logic [4:0]  mis1;
  logic [3:0]  fidx1;
  logic x1;

  logic a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] cap2;
  logic [4:0]  mis2;
  logic [3:0]  fidx2;
  logic x2;

  logic a3, b3, c3, d3, busy3, done3, pass3;
  logic [15:0] cap3;
  logic [4:0]  mis3;
  logic [3:0]  fidx3;
  logic x3;

  int checks = 0;
  int errors = 0;

  assign x1 = mode ? (a1 & b1 & c1 & d1) : 1'b0;
  assign x2 = ~(a2 ^ b2 ^ c2 ^ d2);
  assign x3 = a3 | b3 | c3 | d3;

  tt_sweep_checker #(.EXPECTED(16'h8000), .SETTLE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .captured_o(cap1), .mismatches_o(mis1), .fail_idx_o(fidx1)
  );

  tt_sweep_checker #(.EXPECTED(16'h6996), .SETTLE(1)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x2),
    .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .captured_o(cap2), .mismatches_o(mis2), .fail_idx_o(fidx2)
  );

  tt_sweep_checker #(.EXPECTED(16'hFFFE), .SETTLE(3)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x3),
    .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3),
    .busy_o(busy3), .done_o(done3), .pass_o(pass3),
    .captured_o(cap3), .mismatches_o(mis3), .fail_idx_o(fidx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns at the falling edge after the accepting edge.
  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_abcd",   16'({a1, b1, c1, d1}), 16'h0);
    checkOutput("rst_busy",   16'(busy1), 16'h0);
    checkOutput("rst_done",   16'(done1), 16'h0);
    checkOutput("rst_pass",   16'(pass1), 16'h0);
    checkOutput("rst_cap",    cap1, 16'h0000);
    checkOutput("rst_mis",    16'(mis1), 16'h0);
    checkOutput("rst_fidx",   16'(fidx1), 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // AND gate against 16'h8000, parity inverse against 16'h6996.
    applyStimulus();
    checkOutput("t1_busy0",   16'(busy1), 16'h1);
    checkOutput("t1_vec0",    16'({a1, b1, c1, d1}), 16'h0);
    repeat (15) @(negedge clk);
    checkOutput("t1_busy15",  16'(busy1), 16'h1);
    checkOutput("t1_done15",  16'(done1), 16'h0);
    checkOutput("t1_vec15",   16'({a1, b1, c1, d1}), 16'hF);
    @(negedge clk);
    checkOutput("t1_done",    16'(done1), 16'h1);
    checkOutput("t1_busyend", 16'(busy1), 16'h0);
    checkOutput("t1_pass",    16'(pass1), 16'h1);
    checkOutput("t1_cap",     cap1, 16'h8000);
    checkOutput("t1_mis",     16'(mis1), 16'h0);
    checkOutput("t1_fidx",    16'(fidx1), 16'h0);
    checkOutput("t1_holdF",   16'({a1, b1, c1, d1}), 16'hF);
    checkOutput("par_cap",    cap2, 16'h9669);
    checkOutput("par_mis",    16'(mis2), 16'd16);
    checkOutput("par_fidx",   16'(fidx2), 16'h0);
    checkOutput("par_pass",   16'(pass2), 16'h0);
    checkOutput("par_done",   16'(done2), 16'h1);

    // Restart from DONE with x tied low; a start while busy must be ignored.
    mode = 1'b0;
    applyStimulus();
    checkOutput("t2_donedrop", 16'(done1), 16'h0);
    checkOutput("t2_busy",     16'(busy1), 16'h1);
    checkOutput("t2_capclr",   cap1, 16'h0000);
    repeat (4) @(negedge clk);
    applyStimulus();
    repeat (10) @(negedge clk);
    checkOutput("t2_busy15",  16'(busy1), 16'h1);
    @(negedge clk);
    checkOutput("t2_done",    16'(done1), 16'h1);
    checkOutput("t2_cap",     cap1, 16'h0000);
    checkOutput("t2_mis",     16'(mis1), 16'h1);
    checkOutput("t2_fidx",    16'(fidx1), 16'hF);
    checkOutput("t2_pass",    16'(pass1), 16'h0);

    // Reset mid-sweep discards partial results.
    mode = 1'b1;
    applyStimulus();
    repeat (6) @(negedge clk);
    checkOutput("t3_midmis",  16'(mis2), 16'd6);
    checkOutput("t3_midcap",  cap2, 16'h0029);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t3_rbusy",   16'(busy2), 16'h0);
    checkOutput("t3_rdone",   16'(done2), 16'h0);
    checkOutput("t3_rcap",    cap2, 16'h0000);
    checkOutput("t3_rmis",    16'(mis2), 16'h0);
    checkOutput("t3_rfidx",   16'(fidx2), 16'h0);
    checkOutput("t3_rabcd",   16'({a2, b2, c2, d2}), 16'h0);
    rst = 1'b0;
    applyStimulus();
    repeat (15) @(negedge clk);
    checkOutput("t3_busy15",  16'(busy1), 16'h1);
    @(negedge clk);
    checkOutput("t3_done",    16'(done1), 16'h1);
    checkOutput("t3_pass",    16'(pass1), 16'h1);
    checkOutput("t3_cap",     cap1, 16'h8000);

    // SETTLE=3: each vector held three cycles, done after 48.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();
    checkOutput("t4_busy",    16'(busy3), 16'h1);
    checkOutput("t4_v0a",     16'({a3, b3, c3, d3}), 16'h0);
    repeat (2) @(negedge clk);
    checkOutput("t4_v0b",     16'({a3, b3, c3, d3}), 16'h0);
    @(negedge clk);
    checkOutput("t4_v1",      16'({a3, b3, c3, d3}), 16'h1);
    repeat (3) @(negedge clk);
    checkOutput("t4_v2",      16'({a3, b3, c3, d3}), 16'h2);
    repeat (41) @(negedge clk);
    checkOutput("t4_busy47",  16'(busy3), 16'h1);
    checkOutput("t4_done47",  16'(done3), 16'h0);
    checkOutput("t4_v15",     16'({a3, b3, c3, d3}), 16'hF);
    @(negedge clk);
    checkOutput("t4_done",    16'(done3), 16'h1);
    checkOutput("t4_pass",    16'(pass3), 16'h1);
    checkOutput("t4_cap",     cap3, 16'hFFFE);
    checkOutput("t4_mis",     16'(mis3), 16'h0);

    // Reset and start on the same edge: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("rs_busy",    16'(busy1), 16'h0);
    checkOutput("rs_done",    16'(done3), 16'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
